cipher_cfg_sequencer: RTL and testbench
=======================================

Name: cipher_cfg_sequencer

Overview:
- Controller in front of the dual XOR stream cipher's serial configuration chain.
- Accepts an M-bit key word over a valid/ready handshake and shifts it LSB-first into the cipher chain (cfg_en/cfg_i).
- Optionally reads the chain back through cfg_o and compares it against the loaded word; the chain is restored by recirculation.
- Gates the cipher's tx_en/rx_en so no data moves until a verified key is locked.

Parameters:
- M, 36: length of the cipher configuration chain and width of key_in.
- VERIFY, 1: 1 = run the readback/compare pass after loading; 0 = go straight to RUN after SHIFT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_in  in  M  key/config word, bit 0 shifted first.
- key_valid  in  1  key_in is valid.
- key_ready  out  1  sequencer accepts key_in this cycle.
- tx_req  in  1  requester wants the transmit path enabled.
- rx_req  in  1  requester wants the receive path enabled.
- cfg_en  out  1  shift enable to cipher chain.
- cfg_bit  out  1  serial data to cipher cfg_i.
- cfg_ret  in  1  serial readback from cipher cfg_o.
- tx_en  out  1  cipher transmit enable.
- rx_en  out  1  cipher receive enable.
- busy  out  1  high in SHIFT or VERIFY.
- locked  out  1  high in RUN.
- cfg_err  out  1  sticky verify-mismatch flag.
- state_dbg  out  3  encoded state: IDLE=0, SHIFT=1, VERIFY=2, RUN=3, ERROR=4.

Behaviour:
- Chain model (the cipher side):
  - On each clk with cfg_en=1: chain <= {cfg_i, chain[M-1:1]}; cfg_o = chain[0].
  - After M shifts the chain equals the shifted word exactly.
- Reset (async on rst_n low):
  - state=IDLE, shift register and counter cleared.
  - cfg_en=0, cfg_bit=0, tx_en=0, rx_en=0, busy=0, locked=0, cfg_err=0, key_ready=0 while rst_n low.
- key_ready: combinational, 1 in IDLE, RUN and ERROR; 0 in SHIFT and VERIFY.
- Accept: key_valid & key_ready captures key_in into a shadow register and a shift register, clears cfg_err and the bit counter, and moves to SHIFT on the next edge.
- SHIFT:
  - cfg_en=1, cfg_bit=shift_reg[0]; shift_reg shifts right each cycle.
  - Counter increments 0..M-1; exactly M cycles with cfg_en high.
  - After the M-th cycle: go to VERIFY if VERIFY=1, else RUN.
- VERIFY:
  - cfg_en=1, cfg_bit=cfg_ret (recirculate) for M cycles, counter k=0..M-1.
  - Each cycle compare cfg_ret against shadow[k].
  - Any mismatch: next state ERROR, cfg_err<=1, cfg_en=0 from the next cycle (chain may be left partially rotated).
  - All M bits match: chain is back to the original word; go to RUN.
- RUN:
  - locked=1; cfg_en=0, cfg_bit=0.
  - tx_en = tx_req & locked; rx_en = rx_req & locked. Combinational AND of each input with the registered locked.
  - Dropping tx_req/rx_req clears the matching enable but stays in RUN.
- ERROR:
  - tx_en=rx_en=0, cfg_err=1 (sticky).
  - Leaves only on a new accepted key, which clears cfg_err.
- Re-key while in RUN:
  - An accepted key leaves RUN on the next edge, so locked, tx_en and rx_en are 0 from the first SHIFT cycle.
  - Full SHIFT(+VERIFY) then repeats.
- key_valid while busy: ignored (key_ready=0); the requester holds it.
- tx_req/rx_req outside RUN: no effect.
- Latency, accept to locked:
  - M+1 cycles with VERIFY=0.
  - 2M+1 cycles with VERIFY=1.
- Counter width: clog2(M) bits; the terminal compare is at M-1; no wrap past M-1.
- Reset mid-SHIFT/VERIFY: immediate return to IDLE with all outputs low. The chain contents are then undefined and a reload is required.

Test Plan:
- Load and verify: M=36, VERIFY=1, key_in=36'h9_A5C3_F0E1 -> cfg_en high exactly 72 cycles; cfg_bit sequence in SHIFT = key LSB-first; locked rises 73 cycles after accept; cipher chain model == 36'h9_A5C3_F0E1; cfg_err=0.
- Verify mismatch: chain model corrupts bit 5 (stuck-at-0, key bit 5 = 1 for 36'h...E1 -> bit5=1) -> ERROR entered after VERIFY cycle k=5; cfg_err=1; tx_en/rx_en stay 0 with tx_req=rx_req=1; new key clears cfg_err.
- Gating in RUN: locked, toggle tx_req=1, rx_req=0 then swap -> tx_en/rx_en track the requests the same cycle; both 0 when locked=0.
- Re-key in RUN: key_valid with a new word 36'h0_0000_0001 while tx_req=1 -> tx_en falls on the next edge; after 73 cycles locked=1 and chain==1.
- Busy backpressure and reset: key_valid held during SHIFT -> key_ready=0 and no capture until RUN; assert rst_n=0 at SHIFT cycle 10 -> all outputs 0 asynchronously, state_dbg=0.
- VERIFY=0 build: key 36'hF_FFFF_FFFF -> cfg_en high 36 cycles, locked rises 37 cycles after accept.

Source files
------------

// File: rtl/cipher_cfg_sequencer.sv
// rtl/cipher_cfg_sequencer.sv - loads, optionally verifies, and locks a key in the cipher's serial config chain
// Gates the cipher tx/rx enables until a verified key is resident in the chain.
module cipher_cfg_sequencer #(
  parameter int M      = 36,
  parameter bit VERIFY = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic         tx_req,
  input  logic         rx_req,
  output logic         cfg_en,
  output logic         cfg_bit,
  input  logic         cfg_ret,
  output logic         tx_en,
  output logic         rx_en,
  output logic         busy,
  output logic         locked,
  output logic         cfg_err,
  output logic [2:0]   state_dbg
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_VERIFY = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [M-1:0]  shadow_q, shadow_d;
  logic [M-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          accept;
  logic          cnt_last;

  assign accept   = key_valid & key_ready;
  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    cfg_en   = 1'b0;
    cfg_bit  = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (accept) begin
          shadow_d = key_in;
          shift_d  = key_in;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cfg_en  = 1'b1;
        cfg_bit = shift_q[0];
        shift_d = shift_q >> 1;
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = VERIFY ? ST_VERIFY : ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_VERIFY: begin
        // Feeding the readback straight back in rotates the chain to its original word after M cycles.
        cfg_en  = 1'b1;
        cfg_bit = cfg_ret;
        if (cfg_ret != shadow_q[cnt_q]) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else if (cnt_last) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // key_ready is forced low while reset is held, even though the reset state is IDLE.
  assign key_ready = rst_n & ((state_q == ST_IDLE) | (state_q == ST_RUN) | (state_q == ST_ERROR));
  assign busy      = (state_q == ST_SHIFT) | (state_q == ST_VERIFY);
  assign locked    = (state_q == ST_RUN);
  assign tx_en     = tx_req & locked;
  assign rx_en     = rx_req & locked;
  assign cfg_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cipher_cfg_sequencer.sv
// tb/tb_cipher_cfg_sequencer.sv - self-checking bench with a behavioural cipher chain model
// Covers load/verify, mismatch, gating, re-key with backpressure, async reset and a VERIFY=0 build.
module tb_cipher_cfg_sequencer;
  localparam int M = 36;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [M-1:0] key_in = '0, key_in_b = '0;
  logic         key_valid = 1'b0, key_valid_b = 1'b0;
  logic         tx_req = 1'b0, rx_req = 1'b0;
  logic         key_ready, cfg_en, cfg_bit, cfg_ret, tx_en, rx_en, busy, locked, cfg_err;
  logic [2:0]   state_dbg;
  logic         key_ready_b, cfg_en_b, cfg_bit_b, cfg_ret_b, tx_en_b, rx_en_b, busy_b, locked_b, cfg_err_b;
  logic [2:0]   state_dbg_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cipher_cfg_sequencer #(.M(M), .VERIFY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .tx_req(tx_req), .rx_req(rx_req), .cfg_en(cfg_en), .cfg_bit(cfg_bit), .cfg_ret(cfg_ret),
    .tx_en(tx_en), .rx_en(rx_en), .busy(busy), .locked(locked), .cfg_err(cfg_err),
    .state_dbg(state_dbg)
  );

  cipher_cfg_sequencer #(.M(M), .VERIFY(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_in(key_in_b), .key_valid(key_valid_b), .key_ready(key_ready_b),
    .tx_req(1'b0), .rx_req(1'b0), .cfg_en(cfg_en_b), .cfg_bit(cfg_bit_b), .cfg_ret(cfg_ret_b),
    .tx_en(tx_en_b), .rx_en(rx_en_b), .busy(busy_b), .locked(locked_b), .cfg_err(cfg_err_b),
    .state_dbg(state_dbg_b)
  );

  // Cipher-side chain models; fault_on drops readback bit 5 of the verify pass to 0.
  logic [M-1:0] chain_a = '0, seen_a = '0, chain_b = '0;
  int           en_a = 0, en_b = 0;
  bit           fault_on = 1'b0;

  assign cfg_ret   = chain_a[0] & ~(fault_on && (en_a == M + 5));
  assign cfg_ret_b = chain_b[0];

  always @(posedge clk) begin
    if (key_valid && key_ready) en_a <= 0;
    else if (cfg_en) en_a <= en_a + 1;
    if (cfg_en) begin
      chain_a <= {cfg_bit, chain_a[M-1:1]};
      if (en_a < M) seen_a[en_a] <= cfg_bit;
    end
    if (key_valid_b && key_ready_b) en_b <= 0;
    else if (cfg_en_b) en_b <= en_b + 1;
    if (cfg_en_b) chain_b <= {cfg_bit_b, chain_b[M-1:1]};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M-1:0] rand_key();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[M-1:0];
  endfunction

  // Presents a key, waits for acceptance, returns cycles from the accept cycle to locked/ERROR.
  task automatic run_key(input logic [M-1:0] k, output int lat);
    int n;
    @(negedge clk);
    key_in = k;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    key_valid = 1'b0;
    lat = 1;
    while (!locked && state_dbg != 3'd4 && lat < 400) begin @(negedge clk); lat++; end
  endtask

  initial begin
    logic [M-1:0] k, k3;
    int lat, hits;

    #1;
    check("reset_outputs", {key_ready, cfg_en, cfg_bit, tx_en, rx_en, busy, locked, cfg_err, state_dbg}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_ready", key_ready, 1);
    check("idle_state", state_dbg, 0);

    k = 36'h9_A5C3_F0E1;
    run_key(k, lat);
    check("lock_latency", lat, 2 * M + 1);
    check("cfg_en_cycles", en_a, 2 * M);
    check("shift_sequence", seen_a, k);
    check("chain_word", chain_a, k);
    check("cfg_err_clear", cfg_err, 0);
    check("busy_in_run", busy, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tx_req = 1'($urandom_range(0, 1));
      rx_req = 1'($urandom_range(0, 1));
      #1;
      check("rand_tx_en", tx_en, tx_req);
      check("rand_rx_en", rx_en, rx_req);
    end
    @(negedge clk); tx_req = 1'b1; rx_req = 1'b0; #1;
    check("gate_tx_only", {tx_en, rx_en}, 2'b10);
    @(negedge clk); tx_req = 1'b0; rx_req = 1'b1; #1;
    check("gate_rx_only", {tx_en, rx_en}, 2'b01);
    check("still_run", state_dbg, 3);
    tx_req = 1'b0; rx_req = 1'b0;

    for (int i = 0; i < 3; i++) begin
      k = rand_key();
      run_key(k, lat);
      check("rand_latency", lat, 2 * M + 1);
      check("rand_shift_seq", seen_a, k);
      check("rand_chain", chain_a, k);
    end

    tx_req = 1'b1; rx_req = 1'b1;
    fault_on = 1'b1;
    k = 36'h9_A5C3_F0E1;
    run_key(k, lat);
    check("err_latency", lat, M + 7);
    check("err_state", state_dbg, 4);
    check("err_flag", cfg_err, 1);
    check("err_en_cycles", en_a, M + 6);
    check("err_ready", key_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("err_gating", {tx_en, rx_en, cfg_en}, 0);
    end
    fault_on = 1'b0;
    k = rand_key();
    run_key(k, lat);
    check("recover_err_clr", cfg_err, 0);
    check("recover_locked", locked, 1);
    check("recover_chain", chain_a, k);
    check("recover_tx_en", tx_en, 1);

    k3 = rand_key();
    @(negedge clk);
    key_in = 36'h0_0000_0001;
    key_valid = 1'b1;
    #1;
    check("rekey_ready", key_ready, 1);
    @(negedge clk);
    key_in = k3;
    check("rekey_tx_drop", {tx_en, rx_en, locked, busy, key_ready}, 5'b00010);
    lat = 1; hits = 0;
    while (!locked && lat < 400) begin
      @(negedge clk);
      lat++;
      if (key_ready && !locked) hits++;
    end
    check("busy_backpressure", hits, 0);
    check("rekey_latency", lat, 2 * M + 1);
    check("rekey_chain", chain_a, 1);
    @(negedge clk);
    key_valid = 1'b0;
    lat = 0;
    while (!locked && lat < 400) begin @(negedge clk); lat++; end
    check("held_key_chain", chain_a, k3);
    tx_req = 1'b0; rx_req = 1'b0;

    @(negedge clk);
    key_in = rand_key();
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("shift_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {key_ready, cfg_en, cfg_bit, tx_en, rx_en, busy, locked, cfg_err, state_dbg}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    key_in_b = 36'hF_FFFF_FFFF;
    key_valid_b = 1'b1;
    lat = 0;
    while (!key_ready_b && lat < 200) begin @(negedge clk); lat++; end
    @(negedge clk);
    key_valid_b = 1'b0;
    lat = 1;
    while (!locked_b && lat < 400) begin @(negedge clk); lat++; end
    check("nv_latency", lat, M + 1);
    check("nv_en_cycles", en_b, M);
    check("nv_chain", chain_b, 36'hF_FFFF_FFFF);
    check("nv_err", cfg_err_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
